// File: rtl/xor_rr_scheduler.sv
// rtl/xor_rr_scheduler.sv - round-robin shared XOR datapath with one-entry result slot
module xor_bitwise #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a ^ b;
endmodule

module xor_rr_scheduler #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_a,
  input  logic [N*WIDTH-1:0] req_b,
  output logic [N-1:0]       req_ready,
  output logic               res_valid,
  output logic [WIDTH-1:0]   res_data,
  output logic [ID_W-1:0]    res_id,
  input  logic               res_ready,
  output logic [15:0]        op_count
);
  localparam logic [ID_W-1:0] LAST  = ID_W'(N - 1);
  localparam logic [ID_W:0]   N_EXT = (ID_W + 1)'(N);

  logic [ID_W-1:0]  ptr;
  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [ID_W-1:0]  off;
  logic [ID_W:0]    sum;
  logic [ID_W-1:0]  g;
  logic             found;
  logic             space;
  logic             grant;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] x_res;

  // Rotate requests so ptr sits at bit 0; the lowest set bit is the winner's offset.
  always_comb begin
    dbl   = {req_valid, req_valid} >> ptr;
    rot   = dbl[N-1:0];
    found = 1'b0;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = ID_W'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_EXT) sum = sum - N_EXT;
    g = sum[ID_W-1:0];
  end

  assign space     = !res_valid || res_ready;
  assign grant     = space && found && !rst;
  assign req_ready = grant ? (N'(1) << g) : '0;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (g == ID_W'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  xor_bitwise #(.WIDTH(WIDTH)) u_xor (
    .a (a_sel),
    .b (b_sel),
    .y (x_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      op_count  <= '0;
      ptr       <= '0;
    end else if (grant) begin
      res_valid <= 1'b1;
      res_data  <= x_res;
      res_id    <= g;
      op_count  <= op_count + 16'd1;
      ptr       <= (g == LAST) ? '0 : g + 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_xor_rr_scheduler.sv
// tb/tb_xor_rr_scheduler.sv - self-checking bench for xor_rr_scheduler
module tb_xor_rr_scheduler;
  localparam int WIDTH = 16;
  localparam int N     = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_a;
  logic [N*WIDTH-1:0] req_b;
  logic [N-1:0]       req_ready;
  logic               res_valid;
  logic [WIDTH-1:0]   res_data;
  logic [1:0]         res_id;
  logic               res_ready;
  logic [15:0]        op_count;

  int checks = 0;
  int errors = 0;

  // Reference state: what the output slot and priority must be
  logic             m_known = 1'b0;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_id;
  logic [15:0]      m_count;
  int               m_ptr;

  logic             n_known = 1'b0;
  logic             n_valid;
  logic [WIDTH-1:0] n_data;
  int               n_id;
  logic [15:0]      n_count;
  int               n_ptr;

  xor_rr_scheduler #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // Per-cycle comparison against the model, and next-state computation from the rules
  always @(negedge clk) begin
    int gw;
    int best;
    logic [N-1:0] exp_ready;
    logic [WIDTH-1:0] av, bv;
    gw   = -1;
    best = N;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] === 1'b1 && ((i - m_ptr + N) % N) < best) begin
        best = (i - m_ptr + N) % N;
        gw   = i;
      end
    end
    exp_ready = '0;
    if (rst === 1'b0 && m_known && gw >= 0 && (!m_valid || res_ready === 1'b1))
      exp_ready[gw] = 1'b1;
    if (m_known) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("res_valid", 32'(res_valid), 32'(m_valid));
      if (m_valid) begin
        chk("res_data", 32'(res_data), 32'(m_data));
        chk("res_id", 32'(res_id), 32'(m_id));
      end
      chk("op_count", 32'(op_count), 32'(m_count));
    end
    n_known = m_known; n_valid = m_valid; n_data = m_data;
    n_id = m_id; n_count = m_count; n_ptr = m_ptr;
    if (rst === 1'b1) begin
      n_known = 1'b1; n_valid = 1'b0; n_data = '0; n_id = 0; n_count = '0; n_ptr = 0;
    end else if (exp_ready != 0) begin
      av = req_a[gw*WIDTH +: WIDTH];
      bv = req_b[gw*WIDTH +: WIDTH];
      n_valid = 1'b1; n_data = av ^ bv; n_id = gw;
      n_count = m_count + 16'd1; n_ptr = (gw + 1) % N;
    end else if (m_valid && res_ready === 1'b1) begin
      n_valid = 1'b0;
    end
  end

  always @(posedge clk) begin
    m_known = n_known; m_valid = n_valid; m_data = n_data;
    m_id = n_id; m_count = n_count; m_ptr = n_ptr;
  end

  logic [15:0] exp_d [4];
  int          exp_g [5];

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;

    // Reset with every requester asserted
    req_valid = 4'b1111;
    step; step;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_data", 32'(res_data), 32'h0);
    chk("rst_count", 32'(op_count), 32'h0);
    rst = 1'b0; req_valid = '0;
    step;

    // Single op
    set_op(0, 16'hAAAA, 16'hCCCC);
    req_valid = 4'b0001; res_ready = 1'b1;
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    step;
    req_valid = '0;
    chk("single_valid", 32'(res_valid), 32'h1);
    chk("single_data", 32'(res_data), 32'h6666);
    chk("single_id", 32'(res_id), 32'h0);
    chk("single_count", 32'(op_count), 32'h1);
    chk("model_single_data", 32'(m_data), 32'h6666);
    step;
    chk("drain_valid", 32'(res_valid), 32'h0);

    // Round robin from ptr 0 with all requesters held
    rst = 1'b1; step; rst = 1'b0;
    set_op(0, 16'h1111, 16'h2222); exp_d[0] = 16'h3333;
    set_op(1, 16'h0F0F, 16'h00FF); exp_d[1] = 16'h0FF0;
    set_op(2, 16'h1234, 16'hFFFF); exp_d[2] = 16'hEDCB;
    set_op(3, 16'hF0F0, 16'hAAAA); exp_d[3] = 16'h5A5A;
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 3; exp_g[4] = 0;
    req_valid = 4'b1111; res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_ready", 32'(req_ready), 32'(1 << exp_g[k]));
      step;
      chk("rr_id", 32'(res_id), 32'(exp_g[k]));
      chk("rr_data", 32'(res_data), 32'(exp_d[exp_g[k]]));
    end
    chk("rr_count", 32'(op_count), 32'd5);
    chk("model_rr_data", 32'(m_data), 32'h3333);

    // Backpressure holds the slot and blocks grants
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", 32'(req_ready), 32'h0);
      step;
      chk("bp_valid", 32'(res_valid), 32'h1);
      chk("bp_data", 32'(res_data), 32'h3333);
    end
    res_ready = 1'b1;
    #1 chk("refill_ready", 32'(req_ready), 32'h2);
    step;
    chk("refill_valid", 32'(res_valid), 32'h1);
    chk("refill_data", 32'(res_data), 32'h0FF0);
    chk("refill_id", 32'(res_id), 32'h1);

    // Grant 2, then req1 and req3 together: 3 first
    step;
    chk("prio_last2", 32'(res_id), 32'h2);
    req_valid = 4'b1010;
    #1 chk("prio_first", 32'(req_ready), 32'h8);
    step;
    chk("prio_id3", 32'(res_id), 32'h3);
    #1 chk("prio_second", 32'(req_ready), 32'h2);
    step;
    chk("prio_id1", 32'(res_id), 32'h1);
    chk("prio_data1", 32'(res_data), 32'h0FF0);

    // Reset while the slot is full and all requesters wait
    req_valid = 4'b1111; res_ready = 1'b0;
    step;
    rst = 1'b1;
    #1 chk("mid_rst_ready", 32'(req_ready), 32'h0);
    step;
    rst = 1'b0;
    chk("mid_valid", 32'(res_valid), 32'h0);
    chk("mid_count", 32'(op_count), 32'h0);
    #1 chk("mid_first_grant", 32'(req_ready), 32'h1);
    res_ready = 1'b1;
    step;
    chk("mid_id", 32'(res_id), 32'h0);
    chk("mid_data", 32'(res_data), 32'h3333);

    // Idle: priority must not drift
    req_valid = '0;
    step; step;
    req_valid = 4'b1001;
    #1 chk("idle_prio", 32'(req_ready), 32'h8);
    step;
    req_valid = '0;
    step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
